// File: rtl/risc_pkg.sv
// Shared definitions for the program-counter / branch unit: FSM states,
// condition-code encodings and the default datapath width.
package risc_pkg;

  localparam int PC_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } br_state_e;

  // Condition codes in ir[20:19]; the condition flop evaluates them, not this unit.
  localparam logic [1:0] COND_ZERO = 2'b00;
  localparam logic [1:0] COND_NZ   = 2'b01;
  localparam logic [1:0] COND_PL   = 2'b10;
  localparam logic [1:0] COND_MI   = 2'b11;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Sequencer/condition-flop side signals of the PC and branch unit.
// Optional branch statistics outputs appear when BRANCH_STATS_EN is defined.
interface pc_branch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] bus;
  logic [31:0]         ir;
  logic                inc_req;
  logic                ld_req;
  logic                br_req;
  logic                con;
  logic                con_in;
  logic [PC_WIDTH-1:0] pc;
  logic                busy;
  logic                br_done;
  logic                br_taken;
`ifdef BRANCH_STATS_EN
  logic [15:0]         taken_cnt;
  logic [15:0]         nottaken_cnt;
`endif

  modport master (
    output bus, ir, inc_req, ld_req, br_req, con,
`ifdef BRANCH_STATS_EN
    input  taken_cnt, nottaken_cnt,
`endif
    input  con_in, pc, busy, br_done, br_taken
  );

  modport slave (
    input  bus, ir, inc_req, ld_req, br_req, con,
`ifdef BRANCH_STATS_EN
    output taken_cnt, nottaken_cnt,
`endif
    output con_in, pc, busy, br_done, br_taken
  );
endinterface

// File: rtl/pc_branch_unit_adder.sv
// Combinational PC adder: pc + 1 for fetch increment, or pc + sext(disp)
// for branch target computation, chosen by sel_inc.
module pc_target_adder #(
  parameter int PC_WIDTH     = 32,
  parameter int OFFSET_WIDTH = 19
) (
  input  logic [PC_WIDTH-1:0]     base,
  input  logic [OFFSET_WIDTH-1:0] disp,
  input  logic                    sel_inc,
  output logic [PC_WIDTH-1:0]     sum
);
  logic [PC_WIDTH-1:0] addend;

  // NOTE: the addend is fully assigned on every path, so no latch is inferred.
  always_comb begin
    addend = {{(PC_WIDTH-OFFSET_WIDTH){disp[OFFSET_WIDTH-1]}}, disp};
    if (sel_inc) addend = PC_WIDTH'(1);
  end

  // Wraps modulo 2^PC_WIDTH by truncation.
  assign sum = base + addend;
endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner and conditional-branch resolver (IDLE/EVAL/RESOLVE/DONE).
// Define BRANCH_STATS_EN to add saturating taken/not-taken counters.
module pc_branch_unit
  import risc_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                  OFFSET_WIDTH = 19,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic             clock,
  input logic             reset_n,
  pc_branch_unit_if.slave bu
);
  br_state_e           state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] target_q;
  logic [PC_WIDTH-1:0] sum;
  logic                con_in_q;
  logic                busy_q;
  logic                done_q;
  logic                taken_q;
  logic                unused_ir;

  // Only the displacement field matters here; the condition code goes to the flop.
  assign unused_ir = ^bu.ir[31:OFFSET_WIDTH];

  // In IDLE the adder produces pc+1; in EVAL it produces the branch target.
  pc_target_adder #(
    .PC_WIDTH    (PC_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_adder (
    .base   (pc_q),
    .disp   (bu.ir[OFFSET_WIDTH-1:0]),
    .sel_inc(state == ST_IDLE),
    .sum    (sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
      con_in_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Priority ld > br > inc; losing requests are simply dropped.
          if (bu.ld_req) begin
            pc_q <= bu.bus;
          end else if (bu.br_req) begin
            state    <= ST_EVAL;
            con_in_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (bu.inc_req) begin
            pc_q <= sum;
          end
        end
        ST_EVAL: begin
          target_q <= sum;
          state    <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (bu.con) pc_q <= target_q;
          taken_q  <= bu.con;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          con_in_q <= 1'b0;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          taken_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bu.pc       = pc_q;
  assign bu.con_in   = con_in_q;
  assign bu.busy     = busy_q;
  assign bu.br_done  = done_q;
  assign bu.br_taken = taken_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] nottaken_cnt_q;

  // Counters update at the end of the DONE cycle and hold at 16'hFFFF.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (state == ST_DONE) begin
      if (taken_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      end else begin
        if (nottaken_cnt_q != 16'hFFFF) nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
      end
    end
  end

  assign bu.taken_cnt    = taken_cnt_q;
  assign bu.nottaken_cnt = nottaken_cnt_q;
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit, with a behavioural
// condition-flop model driving con. Stats checks run when BRANCH_STATS_EN is defined.
module tb_pc_branch_unit;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   exp_tcnt;
  int   exp_ncnt;
  logic cflop;

  pc_branch_unit_if #(.PC_WIDTH(32)) bu ();

  pc_branch_unit #(
    .PC_WIDTH    (32),
    .OFFSET_WIDTH(19),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bu     (bu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic cond_eval(input logic [1:0] cc, input logic [31:0] v);
    case (cc)
      2'b00:   return (v == 32'd0);
      2'b01:   return (v != 32'd0);
      2'b10:   return ~v[31];
      default: return v[31];
    endcase
  endfunction

  // Condition flop: samples bus while qualified, output gated by con_in.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)       cflop <= 1'b0;
    else if (bu.con_in) cflop <= cond_eval(bu.ir[20:19], bu.bus);
  end
  assign bu.con = cflop & bu.con_in;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ld(input logic [31:0] v);
    bu.bus = v; bu.ld_req = 1'b1;
    tick();
    bu.ld_req = 1'b0;
  endtask

  task automatic pulse_inc();
    bu.inc_req = 1'b1;
    tick();
    bu.inc_req = 1'b0;
  endtask

  // Runs a branch and returns with the bench sitting in the DONE cycle.
  task automatic run_branch(input string tag, input logic [1:0] cc, input logic [18:0] disp,
                            input logic [31:0] ra, input bit noise,
                            input logic exp_taken, input logic [31:0] exp_pc);
    int cycles;
    bu.ir     = {11'd0, cc, disp};
    bu.br_req = 1'b1;
    tick();
    bu.br_req  = 1'b0;
    bu.bus     = ra;
    bu.inc_req = noise;
    bu.ld_req  = noise;
    check({tag, "_busy_eval"}, 32'(bu.busy), 32'd1);
    check({tag, "_conin_eval"}, 32'(bu.con_in), 32'd1);
    cycles = 1;
    while (!bu.br_done && cycles < 8) begin
      tick();
      cycles++;
      bu.bus = 32'hA5A5_5A5A;
      if (cycles >= 3) begin
        bu.inc_req = 1'b0;
        bu.ld_req  = 1'b0;
      end
    end
    bu.inc_req = 1'b0;
    bu.ld_req  = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'd3);
    check({tag, "_done"}, 32'(bu.br_done), 32'd1);
    check({tag, "_taken"}, 32'(bu.br_taken), 32'(exp_taken));
    check({tag, "_pc"}, bu.pc, exp_pc);
    check({tag, "_busy_done"}, 32'(bu.busy), 32'd0);
    check({tag, "_conin_done"}, 32'(bu.con_in), 32'd0);
    if (exp_taken) exp_tcnt++;
    else           exp_ncnt++;
  endtask

  initial begin
    checks = 0; errors = 0; exp_tcnt = 0; exp_ncnt = 0;
    reset_n = 1'b0;
    bu.bus = '0; bu.ir = '0; bu.inc_req = 1'b0; bu.ld_req = 1'b0; bu.br_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("reset_pc", bu.pc, 32'h0);

    // Asynchronous reset from a non-zero pc.
    pulse_ld(32'h40);
    check("ld_0x40", bu.pc, 32'h40);
    reset_n = 1'b0;
    #1;
    check("async_rst_pc", bu.pc, 32'h0);
    check("async_rst_busy", 32'(bu.busy), 32'd0);
    check("async_rst_conin", 32'(bu.con_in), 32'd0);
    check("async_rst_done", 32'(bu.br_done), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    repeat (3) pulse_inc();
    check("inc_x3", bu.pc, 32'h3);

    // Branch on zero, taken: 0x10 + 5.
    pulse_ld(32'h10);
    run_branch("br_z_taken", 2'b00, 19'h00005, 32'h0, 1'b0, 1'b1, 32'h15);
    tick();
    check("br_z_done_low", 32'(bu.br_done), 32'd0);

    // Branch on non-zero with displacement -2.
    pulse_ld(32'h10);
    run_branch("br_nz_not", 2'b01, 19'h7FFFE, 32'h0, 1'b0, 1'b0, 32'h10);
    tick();
    run_branch("br_nz_taken", 2'b01, 19'h7FFFE, 32'h7, 1'b0, 1'b1, 32'h0E);
    tick();

    // Negative condition, large negative displacement wrapping below zero.
    run_branch("br_mi_taken", 2'b11, 19'h40000, 32'h8000_0000, 1'b0, 1'b1, 32'hFFFC_000E);
    tick();
    run_branch("br_pl_not", 2'b10, 19'h40000, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFC_000E);
    tick();

    // Increment wrap and request priority.
    pulse_ld(32'hFFFF_FFFF);
    pulse_inc();
    check("inc_wrap", bu.pc, 32'h0);
    bu.inc_req = 1'b1;
    pulse_ld(32'h1234);
    bu.inc_req = 1'b0;
    check("ld_beats_inc", bu.pc, 32'h1234);
    bu.br_req = 1'b1;
    pulse_ld(32'h2000);
    bu.br_req = 1'b0;
    check("ld_beats_br_pc", bu.pc, 32'h2000);
    check("ld_beats_br_busy", 32'(bu.busy), 32'd0);

    // Requests during EVAL/RESOLVE are ignored; br_req in DONE is dropped.
    run_branch("br_noise", 2'b00, 19'h00010, 32'h0, 1'b1, 1'b1, 32'h2010);
    bu.br_req = 1'b1;
    tick();
    bu.br_req = 1'b0;
    check("done_brreq_busy", 32'(bu.busy), 32'd0);
    tick();
    check("done_brreq_busy2", 32'(bu.busy), 32'd0);
    check("done_brreq_pc", bu.pc, 32'h2010);

`ifdef BRANCH_STATS_EN
    check("taken_cnt", 32'(bu.taken_cnt), 32'(exp_tcnt));
    check("nottaken_cnt", 32'(bu.nottaken_cnt), 32'(exp_ncnt));
    check("taken_cnt_abs", 32'(bu.taken_cnt), 32'd4);
    check("nottaken_cnt_abs", 32'(bu.nottaken_cnt), 32'd2);
`endif

    // Reset in RESOLVE aborts the branch.
    bu.ir = {11'd0, 2'b00, 19'h00100};
    bu.br_req = 1'b1;
    tick();
    bu.br_req = 1'b0;
    bu.bus = 32'h0;
    tick();
    check("resolve_busy", 32'(bu.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_pc", bu.pc, 32'h0);
    check("abort_busy", 32'(bu.busy), 32'd0);
    check("abort_conin", 32'(bu.con_in), 32'd0);
    tick();
    check("abort_done_rst", 32'(bu.br_done), 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_done_after", 32'(bu.br_done), 32'd0);
    check("abort_pc_after", bu.pc, 32'h0);
    tick();
    check("abort_done_after2", 32'(bu.br_done), 32'd0);
`ifdef BRANCH_STATS_EN
    check("cnt_rst_taken", 32'(bu.taken_cnt), 32'd0);
    check("cnt_rst_nottaken", 32'(bu.nottaken_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
